fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register feeding the decode stage.

---
 rtl/mips_pkg.sv | 13 +
 rtl/if_id_reg.sv | 33 +++
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the fetch stage and its IF/ID register.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: async reset, load enable and squash clear (clear wins over load).
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] inst_nxt,
  input  logic [31:0] pc_plus_4_nxt,
  input  logic        valid_nxt,
  output logic [31:0] inst,
  output logic [31:0] pc_plus_4,
  output logic        valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst      <= NOP_INST;
      pc_plus_4 <= '0;
      valid     <= 1'b0;
    end else if (clear) begin
      inst      <= NOP_INST;
      pc_plus_4 <= '0;
      valid     <= 1'b0;
    end else if (load) begin
      inst      <= inst_nxt;
      pc_plus_4 <= pc_plus_4_nxt;
      valid     <= valid_nxt;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with req/ack imem handshake, stall hold buffer and branch redirect.
// Optional BRANCH_DELAY_SLOT_EN: deliver the instruction after a branch instead of squashing it.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_D,
  input  logic        pc_src_D,
  input  logic [31:0] next_br_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_D,
  output logic [31:0] PC_plus_4_D,
  output logic        valid_D
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         req_q, req_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [31:0]  hold_pc4_q, hold_pc4_d;

  logic         ifid_load, ifid_clear;
  logic [31:0]  ifid_inst, ifid_pc4;

  logic         ack, redirect;
  logic [31:0]  target, pc_plus_4, seq_pc;

  assign ack       = imem_ack & req_q;
  assign redirect  = pc_src_D & valid_D & ~stall_D;
  assign target    = next_br_D & ~32'h0000_0003;
  assign pc_plus_4 = pc_q + 32'd4;

  assign imem_req  = req_q;
  assign imem_addr = pc_q;

`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;

  // Once the delay slot is consumed, fetch continues at the branch target.
  assign seq_pc = redirect ? target : (pend_q ? pend_tgt_q : pc_plus_4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end
`else
  logic [31:0] drain_tgt_q, drain_tgt_d;

  assign seq_pc = pc_plus_4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_tgt_q <= '0;
    end else begin
      drain_tgt_q <= drain_tgt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      hold_inst_q <= '0;
      hold_pc4_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      hold_inst_q <= hold_inst_d;
      hold_pc4_q  <= hold_pc4_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    hold_inst_d = hold_inst_q;
    hold_pc4_d  = hold_pc4_q;
    ifid_load   = 1'b0;
    ifid_clear  = 1'b0;
    ifid_inst   = imem_rdata;
    ifid_pc4    = pc_plus_4;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
`else
    drain_tgt_d = drain_tgt_q;
`endif

    unique case (state_q)
      FETCH: begin
        req_d = 1'b1;
`ifndef BRANCH_DELAY_SLOT_EN
        if (redirect) begin
          ifid_clear = 1'b1;
          if (ack || !req_q) begin
            pc_d = target;
          end else begin
            // The outstanding request must still be acked before the target is issued.
            state_d     = DRAIN;
            drain_tgt_d = target;
          end
        end else
`endif
        if (ack && !stall_D) begin
          ifid_load = 1'b1;
          pc_d      = seq_pc;
        end else if (ack) begin
          hold_inst_d = imem_rdata;
          hold_pc4_d  = pc_plus_4;
          pc_d        = seq_pc;
          req_d       = 1'b0;
          state_d     = HOLD;
        end else if (!stall_D) begin
          ifid_clear = 1'b1;
        end
`ifdef BRANCH_DELAY_SLOT_EN
        if (ack) begin
          pend_d = 1'b0;
        end else if (redirect) begin
          pend_d     = 1'b1;
          pend_tgt_d = target;
        end
`endif
      end

      HOLD: begin
        req_d = 1'b0;
        if (!stall_D) begin
          state_d   = FETCH;
          req_d     = 1'b1;
          ifid_inst = hold_inst_q;
          ifid_pc4  = hold_pc4_q;
`ifdef BRANCH_DELAY_SLOT_EN
          // The held word is the delay slot of a branch now leaving decode.
          ifid_load = 1'b1;
          if (redirect) pc_d = target;
`else
          if (redirect) begin
            ifid_clear = 1'b1;
            pc_d       = target;
          end else begin
            ifid_load = 1'b1;
          end
`endif
        end
      end

      DRAIN: begin
        req_d = 1'b1;
`ifndef BRANCH_DELAY_SLOT_EN
        if (ack) begin
          pc_d    = drain_tgt_q;
          state_d = FETCH;
        end
`endif
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (ifid_load),
    .clear         (ifid_clear),
    .inst_nxt      (ifid_inst),
    .pc_plus_4_nxt (ifid_pc4),
    .valid_nxt     (1'b1),
    .inst          (inst_D),
    .pc_plus_4     (PC_plus_4_D),
    .valid         (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; imem returns {8'hE0, addr[23:0]} for every address.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_D;
  logic        pc_src_D;
  logic [31:0] next_br_D;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_D;
  logic [31:0] PC_plus_4_D;
  logic        valid_D;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_D     (stall_D),
    .pc_src_D    (pc_src_D),
    .next_br_D   (next_br_D),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_D      (inst_D),
    .PC_plus_4_D (PC_plus_4_D),
    .valid_D     (valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = {8'hE0, imem_addr[23:0]};

  task automatic test_reset();
    rst_n = 1'b0; stall_D = 1'b0; pc_src_D = 1'b0; next_br_D = '0; imem_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %h exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL rst_addr got %h exp 00400000", imem_addr); end
    checks++; if (inst_D !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 0", inst_D); end
    checks++; if (PC_plus_4_D !== 32'h0) begin errors++; $display("FAIL rst_pc4 got %h exp 0", PC_plus_4_D); end
    checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL rst_valid got %h exp 0", valid_D); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %h exp 1", imem_req); end
  endtask

  task automatic test_back_to_back();
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL b2b_addr0 got %h exp 00400000", imem_addr); end
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0040_0004) begin errors++; $display("FAIL b2b_addr1 got %h exp 00400004", imem_addr); end
    checks++; if (PC_plus_4_D !== 32'h0040_0004) begin errors++; $display("FAIL b2b_pc4_0 got %h exp 00400004", PC_plus_4_D); end
    checks++; if (inst_D !== 32'hE040_0000) begin errors++; $display("FAIL b2b_inst0 got %h exp E0400000", inst_D); end
    checks++; if (valid_D !== 1'b1) begin errors++; $display("FAIL b2b_valid0 got %h exp 1", valid_D); end
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL b2b_addr2 got %h exp 00400008", imem_addr); end
    checks++; if (PC_plus_4_D !== 32'h0040_0008) begin errors++; $display("FAIL b2b_pc4_1 got %h exp 00400008", PC_plus_4_D); end
    checks++; if (valid_D !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %h exp 1", valid_D); end
    imem_ack = 1'b0;
  endtask

  task automatic test_slow_ack();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (imem_addr !== 32'h0040_0008) begin errors++; $display("FAIL slow_addr%0d got %h exp 00400008", i, imem_addr); end
      checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL slow_bubble%0d got %h exp 0", i, valid_D); end
    end
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if (inst_D !== 32'hE040_0008) begin errors++; $display("FAIL slow_inst got %h exp E0400008", inst_D); end
    checks++; if (PC_plus_4_D !== 32'h0040_000C) begin errors++; $display("FAIL slow_pc4 got %h exp 0040000C", PC_plus_4_D); end
    checks++; if (valid_D !== 1'b1) begin errors++; $display("FAIL slow_valid got %h exp 1", valid_D); end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall();
    stall_D = 1'b1; imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req%0d got %h exp 0", i, imem_req); end
      checks++; if (inst_D !== 32'hE040_0008) begin errors++; $display("FAIL stall_inst%0d got %h exp E0400008", i, inst_D); end
      checks++; if (PC_plus_4_D !== 32'h0040_000C) begin errors++; $display("FAIL stall_pc4%0d got %h exp 0040000C", i, PC_plus_4_D); end
    end
    stall_D = 1'b0;
    @(negedge clk);
    checks++; if (inst_D !== 32'hE040_000C) begin errors++; $display("FAIL held_inst got %h exp E040000C", inst_D); end
    checks++; if (PC_plus_4_D !== 32'h0040_0010) begin errors++; $display("FAIL held_pc4 got %h exp 00400010", PC_plus_4_D); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL held_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0010) begin errors++; $display("FAIL held_addr got %h exp 00400010", imem_addr); end
    @(negedge clk);
    checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL held_once got %h exp 0", valid_D); end
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if (inst_D !== 32'hE040_0010) begin errors++; $display("FAIL after_hold_inst got %h exp E0400010", inst_D); end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_ack();
    pc_src_D = 1'b1; next_br_D = 32'h0040_0103; imem_ack = 1'b1;
    @(negedge clk);
    pc_src_D = 1'b0;
    checks++; if (imem_addr !== 32'h0040_0100) begin errors++; $display("FAIL redir_addr got %h exp 00400100", imem_addr); end
`ifdef BRANCH_DELAY_SLOT_EN
    checks++; if (inst_D !== 32'hE040_0014) begin errors++; $display("FAIL ds_slot_inst got %h exp E0400014", inst_D); end
    checks++; if (valid_D !== 1'b1) begin errors++; $display("FAIL ds_slot_valid got %h exp 1", valid_D); end
`else
    checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL redir_bubble got %h exp 0", valid_D); end
    checks++; if (inst_D !== 32'h0) begin errors++; $display("FAIL redir_squash got %h exp 0", inst_D); end
`endif
    @(negedge clk);
    checks++; if (inst_D !== 32'hE040_0100) begin errors++; $display("FAIL redir_tgt_inst got %h exp E0400100", inst_D); end
    checks++; if (PC_plus_4_D !== 32'h0040_0104) begin errors++; $display("FAIL redir_tgt_pc4 got %h exp 00400104", PC_plus_4_D); end
    imem_ack = 1'b0;
  endtask

  task automatic test_redirect_drain();
    pc_src_D = 1'b1; next_br_D = 32'h0040_0200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      pc_src_D = 1'b0;
      checks++; if (imem_addr !== 32'h0040_0104) begin errors++; $display("FAIL drain_addr%0d got %h exp 00400104", i, imem_addr); end
      checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL drain_valid%0d got %h exp 0", i, valid_D); end
    end
    imem_ack = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0040_0200) begin errors++; $display("FAIL drain_tgt got %h exp 00400200", imem_addr); end
`ifdef BRANCH_DELAY_SLOT_EN
    checks++; if (inst_D !== 32'hE040_0104) begin errors++; $display("FAIL ds_drain_slot got %h exp E0400104", inst_D); end
`else
    checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL drain_discard got %h exp 0", valid_D); end
`endif
    @(negedge clk);
    checks++; if (inst_D !== 32'hE040_0200) begin errors++; $display("FAIL drain_inst got %h exp E0400200", inst_D); end
    checks++; if (PC_plus_4_D !== 32'h0040_0204) begin errors++; $display("FAIL drain_pc4 got %h exp 00400204", PC_plus_4_D); end
    imem_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req got %h exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL arst_addr got %h exp 00400000", imem_addr); end
    checks++; if (valid_D !== 1'b0) begin errors++; $display("FAIL arst_valid got %h exp 0", valid_D); end
    checks++; if (inst_D !== 32'h0) begin errors++; $display("FAIL arst_inst got %h exp 0", inst_D); end
    checks++; if (PC_plus_4_D !== 32'h0) begin errors++; $display("FAIL arst_pc4 got %h exp 0", PC_plus_4_D); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL restart_req got %h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0040_0000) begin errors++; $display("FAIL restart_addr got %h exp 00400000", imem_addr); end
  endtask

  task automatic test_pc_wrap();
    imem_ack = 1'b1;
    @(negedge clk);
    pc_src_D = 1'b1; next_br_D = 32'hFFFF_FFFF;
    @(negedge clk);
    pc_src_D = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp FFFFFFFC", imem_addr); end
    @(negedge clk);
    checks++; if (PC_plus_4_D !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h exp 0", PC_plus_4_D); end
    checks++; if (inst_D !== 32'hE0FF_FFFC) begin errors++; $display("FAIL wrap_inst got %h exp E0FFFFFC", inst_D); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", imem_addr); end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall_redirect();
    stall_D = 1'b1; pc_src_D = 1'b1; next_br_D = 32'h0050_0000;
    @(negedge clk);
    stall_D = 1'b0; pc_src_D = 1'b0;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL stall_br_addr got %h exp 0", imem_addr); end
    checks++; if (valid_D !== 1'b1) begin errors++; $display("FAIL stall_br_valid got %h exp 1", valid_D); end
    checks++; if (inst_D !== 32'hE0FF_FFFC) begin errors++; $display("FAIL stall_br_inst got %h exp E0FFFFFC", inst_D); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_slow_ack();
    test_stall();
    test_redirect_ack();
    test_redirect_drain();
    test_async_reset();
    test_pc_wrap();
    test_stall_redirect();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
